// File: rtl/branch_predictor.sv
// ---------------------------------------------------------------------------
// branch_predictor
//
// Fetch-side direction predictor and branch target buffer. Every cycle it
// offers the IF stage a next-PC guess for if_pc. It checks the EX-stage
// resolved outcome against the guess carried down the pipeline, raises a
// flush/redirect on disagreement, and trains a direct-mapped table of 2-bit
// saturating counters and targets on every resolved branch or JAL. It also
// keeps saturating counts of resolved control-flow instructions and of
// mispredicts.
//
// Ports
//   clk             system clock, rising edge
//   reset           asynchronous, active-high reset
//   if_pc           PC being fetched
//   pred_taken      predicted direction for if_pc
//   pred_target     predicted next PC for if_pc
//   ex_valid        EX stage holds a live instruction
//   ex_opcode       opcode of the EX instruction
//   ex_pc           PC of the EX instruction
//   ex_br_taken     resolved direction from the branch condition unit
//   ex_target       resolved target (PC plus immediate)
//   ex_pred_taken   pred_taken captured at fetch, carried to EX
//   ex_pred_target  pred_target captured at fetch, carried to EX
//   mispredict      flush IF/ID and redirect fetch this cycle
//   redirect_pc     correct next PC, valid while mispredict = 1
//   br_count        resolved control-flow instructions, saturating
//   mp_count        mispredicts, saturating
// ---------------------------------------------------------------------------
module branch_predictor #(
   parameter int ENTRIES = 16,
   parameter int INDEX_W = $clog2(ENTRIES)
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] if_pc,
   output logic        pred_taken,
   output logic [31:0] pred_target,
   input  logic        ex_valid,
   input  logic [6:0]  ex_opcode,
   input  logic [31:0] ex_pc,
   input  logic        ex_br_taken,
   input  logic [31:0] ex_target,
   input  logic        ex_pred_taken,
   input  logic [31:0] ex_pred_target,
   output logic        mispredict,
   output logic [31:0] redirect_pc,
   output logic [15:0] br_count,
   output logic [15:0] mp_count
);

   localparam int          TAG_W     = 30 - INDEX_W;
   localparam logic [6:0]  OP_BRANCH = 7'b1100011;
   localparam logic [6:0]  OP_JAL    = 7'b1101111;
   localparam logic [1:0]  CTR_RESET = 2'd1;
   localparam logic [15:0] CNT_MAX   = 16'hFFFF;

   // Table state
   logic               r_valid  [ENTRIES];
   logic [TAG_W-1:0]   r_tag    [ENTRIES];
   logic [31:0]        r_target [ENTRIES];
   logic [1:0]         r_ctr    [ENTRIES];

   logic [15:0]        r_br_count;
   logic [15:0]        r_mp_count;

   // Lookup side
   logic [INDEX_W-1:0] w_if_idx;
   logic [TAG_W-1:0]   w_if_tag;
   logic               w_if_hit;
   logic               w_pred_taken;

   // Resolve side
   logic [INDEX_W-1:0] w_ex_idx;
   logic [TAG_W-1:0]   w_ex_tag;
   logic               w_ex_hit;
   logic               w_is_branch;
   logic               w_is_jal;
   logic               w_ctl;
   logic               w_dir_wrong;
   logic               w_tgt_wrong;
   logic               w_mispredict;

   // ------------------------------------------------------------------
   // Lookup: combinational against registered table state, no bypass
   // from a same-cycle update.
   // ------------------------------------------------------------------
   assign w_if_idx     = if_pc[INDEX_W+1:2];
   assign w_if_tag     = if_pc[31:INDEX_W+2];
   assign w_if_hit     = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);
   assign w_pred_taken = w_if_hit && r_ctr[w_if_idx][1];

   assign pred_taken   = w_pred_taken;
   assign pred_target  = w_pred_taken ? r_target[w_if_idx] : (if_pc + 32'd4);

   // ------------------------------------------------------------------
   // Resolve
   // ------------------------------------------------------------------
   assign w_ex_idx    = ex_pc[INDEX_W+1:2];
   assign w_ex_tag    = ex_pc[31:INDEX_W+2];
   assign w_ex_hit    = r_valid[w_ex_idx] && (r_tag[w_ex_idx] == w_ex_tag);

   assign w_is_branch = (ex_opcode == OP_BRANCH);
   assign w_is_jal    = (ex_opcode == OP_JAL);
   assign w_ctl       = ex_valid && (w_is_branch || w_is_jal);

   // A correctly-predicted taken branch can still go wrong if the cached
   // target is stale, so the target only matters when actually taken.
   assign w_dir_wrong  = (ex_br_taken != ex_pred_taken);
   assign w_tgt_wrong  = ex_br_taken && (ex_target != ex_pred_target);
   assign w_mispredict = !reset && w_ctl && (w_dir_wrong || w_tgt_wrong);

   assign mispredict   = w_mispredict;
   assign redirect_pc  = ex_br_taken ? ex_target : (ex_pc + 32'd4);

   // ------------------------------------------------------------------
   // Table training
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < ENTRIES; i++) begin
            r_valid[i]  <= 1'b0;
            r_tag[i]    <= '0;
            r_target[i] <= '0;
            r_ctr[i]    <= CTR_RESET;
         end
      end else if (w_ctl) begin
         if (w_ex_hit) begin
            if (w_is_jal) begin
               r_ctr[w_ex_idx]    <= 2'd3;
               r_target[w_ex_idx] <= ex_target;
            end else if (ex_br_taken) begin
               if (r_ctr[w_ex_idx] != 2'd3) begin
                  r_ctr[w_ex_idx] <= r_ctr[w_ex_idx] + 2'd1;
               end
               r_target[w_ex_idx] <= ex_target;
            end else begin
               if (r_ctr[w_ex_idx] != 2'd0) begin
                  r_ctr[w_ex_idx] <= r_ctr[w_ex_idx] - 2'd1;
               end
            end
         end else if (ex_br_taken) begin
            // Allocation evicts whatever occupies the slot. JALs start
            // strongly taken since they are unconditional.
            r_valid[w_ex_idx]  <= 1'b1;
            r_tag[w_ex_idx]    <= w_ex_tag;
            r_target[w_ex_idx] <= ex_target;
            r_ctr[w_ex_idx]    <= w_is_jal ? 2'd3 : 2'd2;
         end
      end
   end

   // ------------------------------------------------------------------
   // Statistics, saturating at all-ones
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_br_count <= '0;
         r_mp_count <= '0;
      end else begin
         if (w_ctl && (r_br_count != CNT_MAX)) begin
            r_br_count <= r_br_count + 16'd1;
         end
         if (w_mispredict && (r_mp_count != CNT_MAX)) begin
            r_mp_count <= r_mp_count + 16'd1;
         end
      end
   end

   assign br_count = r_br_count;
   assign mp_count = r_mp_count;

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

   localparam logic [6:0] OP_BR  = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;
   localparam logic [6:0] OP_ALU = 7'b0110011;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] if_pc;
   logic        pred_taken;
   logic [31:0] pred_target;
   logic        ex_valid;
   logic [6:0]  ex_opcode;
   logic [31:0] ex_pc;
   logic        ex_br_taken;
   logic [31:0] ex_target;
   logic        ex_pred_taken;
   logic [31:0] ex_pred_target;
   logic        mispredict;
   logic [31:0] redirect_pc;
   logic [15:0] br_count;
   logic [15:0] mp_count;

   int checks   = 0;
   int failures = 0;

   branch_predictor #(.ENTRIES(16)) dut (
      .clk            (clk),
      .reset          (reset),
      .if_pc          (if_pc),
      .pred_taken     (pred_taken),
      .pred_target    (pred_target),
      .ex_valid       (ex_valid),
      .ex_opcode      (ex_opcode),
      .ex_pc          (ex_pc),
      .ex_br_taken    (ex_br_taken),
      .ex_target      (ex_target),
      .ex_pred_taken  (ex_pred_taken),
      .ex_pred_target (ex_pred_target),
      .mispredict     (mispredict),
      .redirect_pc    (redirect_pc),
      .br_count       (br_count),
      .mp_count       (mp_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ex(input logic v, input logic [6:0] opc, input logic [31:0] pc,
                         input logic tk, input logic [31:0] tgt,
                         input logic ptk, input logic [31:0] ptgt);
      ex_valid       = v;
      ex_opcode      = opc;
      ex_pc          = pc;
      ex_br_taken    = tk;
      ex_target      = tgt;
      ex_pred_taken  = ptk;
      ex_pred_target = ptgt;
   endtask

   task automatic idle_ex();
      set_ex(1'b0, 7'd0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
   endtask

   initial begin
      // Reset held, with EX showing a would-be mispredict
      reset = 1'b1;
      if_pc = 32'h0000_0100;
      set_ex(1'b1, OP_BR, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
      #1;
      chk("rst_mispredict", {31'd0, mispredict}, 32'd0);
      chk("rst_pred_taken", {31'd0, pred_taken}, 32'd0);
      chk("rst_pred_target", pred_target, 32'h104);
      chk("rst_br_count", {16'd0, br_count}, 32'd0);
      chk("rst_mp_count", {16'd0, mp_count}, 32'd0);
      tick();
      chk("rst_no_update", {31'd0, pred_taken}, 32'd0);
      chk("rst_no_count", {16'd0, br_count}, 32'd0);
      reset = 1'b0;
      #1;

      // Cold BEQ taken, predicted not taken
      chk("cold_mispredict", {31'd0, mispredict}, 32'd1);
      chk("cold_redirect", redirect_pc, 32'h80);
      chk("cold_no_bypass", {31'd0, pred_taken}, 32'd0);
      tick();
      idle_ex();
      #1;
      chk("alloc_pred_taken", {31'd0, pred_taken}, 32'd1);
      chk("alloc_pred_target", pred_target, 32'h80);
      chk("alloc_br_count", {16'd0, br_count}, 32'd1);
      chk("alloc_mp_count", {16'd0, mp_count}, 32'd1);

      // Not taken: ctr 2 -> 1, predicted taken so mispredict
      set_ex(1'b1, OP_BR, 32'h100, 1'b0, 32'h80, 1'b1, 32'h80);
      #1;
      chk("nt1_mispredict", {31'd0, mispredict}, 32'd1);
      chk("nt1_redirect", redirect_pc, 32'h104);
      tick();
      idle_ex();
      #1;
      chk("nt1_pred_taken", {31'd0, pred_taken}, 32'd0);
      chk("nt1_pred_target", pred_target, 32'h104);

      // Not taken: ctr 1 -> 0, predicted not taken
      set_ex(1'b1, OP_BR, 32'h100, 1'b0, 32'h80, 1'b0, 32'h104);
      #1;
      chk("nt2_mispredict", {31'd0, mispredict}, 32'd0);
      tick();
      idle_ex();
      #1;
      chk("nt2_pred_taken", {31'd0, pred_taken}, 32'd0);

      // Not taken: ctr stays at 0
      set_ex(1'b1, OP_BR, 32'h100, 1'b0, 32'h80, 1'b0, 32'h104);
      #1;
      chk("nt3_mispredict", {31'd0, mispredict}, 32'd0);
      tick();
      idle_ex();
      #1;
      chk("nt3_pred_taken", {31'd0, pred_taken}, 32'd0);
      chk("nt_br_count", {16'd0, br_count}, 32'd4);
      chk("nt_mp_count", {16'd0, mp_count}, 32'd2);

      // Taken: ctr 0 -> 1, still predicts not taken (no underflow wrap)
      set_ex(1'b1, OP_BR, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
      #1;
      chk("t1_mispredict", {31'd0, mispredict}, 32'd1);
      tick();
      idle_ex();
      #1;
      chk("t1_pred_taken", {31'd0, pred_taken}, 32'd0);

      // Taken: ctr 1 -> 2
      set_ex(1'b1, OP_BR, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
      tick();
      idle_ex();
      #1;
      chk("t2_pred_taken", {31'd0, pred_taken}, 32'd1);
      chk("t2_pred_target", pred_target, 32'h80);

      // Right direction, stale target
      set_ex(1'b1, OP_BR, 32'h100, 1'b1, 32'h200, 1'b1, 32'h80);
      #1;
      chk("stale_mispredict", {31'd0, mispredict}, 32'd1);
      chk("stale_redirect", redirect_pc, 32'h200);
      tick();
      idle_ex();
      #1;
      chk("stale_pred_target", pred_target, 32'h200);

      // Fully correct prediction
      set_ex(1'b1, OP_BR, 32'h100, 1'b1, 32'h200, 1'b1, 32'h200);
      #1;
      chk("ok_mispredict", {31'd0, mispredict}, 32'd0);
      tick();
      idle_ex();
      #1;
      chk("ok_br_count", {16'd0, br_count}, 32'd8);
      chk("ok_mp_count", {16'd0, mp_count}, 32'd5);

      // JAL allocate at 0x40 (same index as 0x100, evicts it), ctr = 3
      set_ex(1'b1, OP_JAL, 32'h40, 1'b1, 32'h1000, 1'b0, 32'h44);
      tick();
      idle_ex();
      if_pc = 32'h40;
      #1;
      chk("jal_pred_taken", {31'd0, pred_taken}, 32'd1);
      chk("jal_pred_target", pred_target, 32'h1000);
      if_pc = 32'h100;
      #1;
      chk("evict_pred_target", pred_target, 32'h104);

      // One not-taken on 0x40: 3 -> 2 keeps predicting taken, target kept
      set_ex(1'b1, OP_BR, 32'h40, 1'b0, 32'h1000, 1'b1, 32'h1000);
      #1;
      chk("jnt_redirect", redirect_pc, 32'h44);
      tick();
      idle_ex();
      if_pc = 32'h40;
      #1;
      chk("jnt_pred_taken", {31'd0, pred_taken}, 32'd1);
      chk("jnt_pred_target", pred_target, 32'h1000);

      // Alias 0x440 onto index 0
      if_pc = 32'h440;
      #1;
      chk("alias_pre_miss", pred_target, 32'h444);
      set_ex(1'b1, OP_BR, 32'h440, 1'b1, 32'h2000, 1'b0, 32'h444);
      tick();
      idle_ex();
      if_pc = 32'h40;
      #1;
      chk("alias_old_miss", pred_target, 32'h44);
      chk("alias_old_taken", {31'd0, pred_taken}, 32'd0);
      if_pc = 32'h440;
      #1;
      chk("alias_new_hit", pred_target, 32'h2000);
      chk("alias_br_count", {16'd0, br_count}, 32'd11);
      chk("alias_mp_count", {16'd0, mp_count}, 32'd8);

      // Non-control opcode is ignored
      set_ex(1'b1, OP_ALU, 32'h440, 1'b1, 32'h3000, 1'b0, 32'h444);
      #1;
      chk("alu_mispredict", {31'd0, mispredict}, 32'd0);
      tick();
      // Invalid EX slot with a branch opcode is ignored too
      set_ex(1'b0, OP_BR, 32'h440, 1'b1, 32'h3000, 1'b0, 32'h444);
      #1;
      chk("inv_mispredict", {31'd0, mispredict}, 32'd0);
      tick();
      idle_ex();
      #1;
      chk("ign_pred_target", pred_target, 32'h2000);
      chk("ign_br_count", {16'd0, br_count}, 32'd11);
      chk("ign_mp_count", {16'd0, mp_count}, 32'd8);

      // Wrap of if_pc + 4
      if_pc = 32'hFFFF_FFFC;
      #1;
      chk("wrap_pred_target", pred_target, 32'h0);
      if_pc = 32'h440;

      // Mid-cycle asynchronous reset
      #2;
      reset = 1'b1;
      #1;
      chk("async_pred_taken", {31'd0, pred_taken}, 32'd0);
      chk("async_pred_target", pred_target, 32'h444);
      chk("async_br_count", {16'd0, br_count}, 32'd0);
      chk("async_mp_count", {16'd0, mp_count}, 32'd0);
      reset = 1'b0;

      // Statistics saturation: mispredict every cycle
      tick();
      set_ex(1'b1, OP_BR, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
      for (int i = 0; i < 65534; i++) tick();
      chk("sat_br_fffe", {16'd0, br_count}, 32'hFFFE);
      chk("sat_mp_fffe", {16'd0, mp_count}, 32'hFFFE);
      for (int i = 0; i < 6; i++) tick();
      chk("sat_br_hold", {16'd0, br_count}, 32'hFFFF);
      chk("sat_mp_hold", {16'd0, mp_count}, 32'hFFFF);
      idle_ex();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Fetch-side direction predictor and branch target buffer: the consumer of the execute-stage `br_taken` resolution. It gives the IF stage a next-PC guess every cycle. It compares the EX-stage resolved outcome against the guess carried down the pipeline, raising a flush/redirect on mismatch. On each resolved branch or JAL it trains a direct-mapped table of 2-bit saturating counters and targets, and it keeps saturating branch and mispredict statistics counters.

## Interface
- `ENTRIES`, default 16: number of table entries, power of two, range 4 to 256.
- `INDEX_W`, default $clog2(ENTRIES): index width, derived, not overridden.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `if_pc`  in  32  PC currently being fetched.
- `pred_taken`  out  1  prediction for `if_pc`.
- `pred_target`  out  32  predicted next PC for `if_pc`.
- `ex_valid`  in  1  EX stage holds a live instruction; the pipeline drops it when EX is flushed.
- `ex_opcode`  in  7  opcode of the EX instruction.
- `ex_pc`  in  32  PC of the EX instruction.
- `ex_br_taken`  in  1  resolved outcome from the branch condition unit.
- `ex_target`  in  32  computed target, PC plus immediate.
- `ex_pred_taken`  in  1  `pred_taken` captured at fetch and carried to EX.
- `ex_pred_target`  in  32  `pred_target` captured at fetch and carried to EX.
- `mispredict`  out  1  flush IF/ID and redirect fetch this cycle.
- `redirect_pc`  out  32  correct next PC, meaningful when `mispredict` = 1.
- `br_count`  out  16  resolved control-flow instructions, saturating.
- `mp_count`  out  16  mispredicts, saturating.

## Operation
- Entry fields: `valid`, `tag` (30−INDEX_W bits, `pc[31:INDEX_W+2]`), `target` (32 bits), `ctr` (2 bits). Index is `pc[INDEX_W+1:2]`.
- Lookup: `hit` = `valid` & tag match for `if_pc`.
  - `pred_taken` = `hit` & `ctr[1]`.
  - `pred_target` = `pred_taken` ? entry `target` : `if_pc`+4. Addition wraps modulo 2^32.
- Resolve: `ctl` = `ex_valid` & (`ex_opcode` == 1100011 or 1101111). All other opcodes are ignored: no update, no mispredict, no count.
- `mispredict` = `ctl` & ((`ex_br_taken` != `ex_pred_taken`) | (`ex_br_taken` & `ex_target` != `ex_pred_target`)).
- `redirect_pc` = `ex_br_taken` ? `ex_target` : `ex_pc`+4.
- Update, at the clock edge when `ctl` = 1, on the `ex_pc` entry:
  - Hit, conditional branch: `ctr` increments if taken, saturating at 3, and decrements if not taken, saturating at 0. `target` is overwritten with `ex_target` only when taken.
  - Hit, JAL (1101111): `ctr` becomes 3 and `target` becomes `ex_target`.
  - Miss and taken: allocate, overwriting any existing occupant. `valid`=1, `tag`, `target`=`ex_target`, `ctr`=2 for a branch or 3 for a JAL.
  - Miss and not taken: no allocation, table unchanged.
- Counters: `br_count` increments on every `ctl` cycle. `mp_count` increments on every `mispredict` cycle. Both hold at FFFF.

## Timing
- Lookup is combinational from `if_pc` against registered table state, zero-cycle latency.
- `mispredict` and `redirect_pc` are combinational from the EX inputs in the same cycle. The pipeline applies the flush at the next edge.
- A table write at edge N is visible to lookups from cycle N+1 on.
- Same-index lookup and update in one cycle: the lookup returns the pre-update contents. There is no bypass.
- A single update port gives one update per cycle.
- Reset (asynchronous, may assert mid-operation):
  - Every `valid` clears, every `ctr` becomes 1, and both statistics counters clear immediately.
  - `mispredict` is forced to 0 while `reset` is high.
  - With an empty table, `pred_taken`=0 and `pred_target`=`if_pc`+4.
  - No update occurs on any edge where `reset` is high.
- `if_pc` = FFFFFFFC gives `pred_target` = 00000000 on a miss.

## Test plan
- Cold table, BEQ at `ex_pc`=00000100, taken, target 00000080, `ex_pred_taken`=0 → `mispredict`=1, `redirect_pc`=00000080. Next cycle, `if_pc`=00000100 gives `pred_taken`=1 and `pred_target`=00000080. `br_count`=1, `mp_count`=1.
- Same BEQ resolved not taken three times with a correctly carried prediction → `ctr` goes 2→1→0→0. `pred_taken` is 0 from the second resolution onward. `redirect_pc`=00000104 on each mispredict.
- Correct direction but stale target: taken, `ex_target`=00000200, `ex_pred_target`=00000080 → `mispredict`=1, `redirect_pc`=00000200, entry `target` becomes 00000200.
- With ENTRIES=16, PCs 00000040 and 00000440 alias to index 0 with different tags. Allocate 00000040, then resolve 00000440 taken → 00000040 now misses (`pred_target`=00000044) and 00000440 hits.
- `ex_opcode`=0110011 with `ex_valid`=1 and `ex_br_taken`=1 → `mispredict`=0, no table change, counters unchanged. Then `reset` is pulsed mid-cycle after training → `pred_taken`=0 with no clock edge, and both counters read 0.
- 65540 consecutive mispredicting branches → `mp_count` and `br_count` both hold at FFFF.
